data_memory_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 21 ++
 rtl/byte_lane_merge.sv | 34 +++
 rtl/data_memory_responder.sv | 184 ++++++++++++++++++
 tb/tb_data_memory_responder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Provides the FSM state enum, byte-lane geometry and an index-width helper.
// No ports; imported by data_memory_responder and byte_lane_merge.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_e;

    localparam int LANE_W         = 8;
    localparam int LANES_PER_WORD = 4;
    localparam int WORD_W         = LANE_W * LANES_PER_WORD;

    // Number of word-index bits needed to address depth_words entries.
    function automatic int index_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Byte-lane merge/extract for little-endian word memory.
// Ports: old_word (current array word), store_data (bits [7:0] used for bytes),
//        lane (byte lane, 0 = bits [7:0]), is_byte (1 = byte access),
//        new_word (word to write back), load_data (word or zero-extended byte).
module byte_lane_merge
    import dmem_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] store_data,
    input  logic [1:0]        lane,
    input  logic              is_byte,
    output logic [WORD_W-1:0] new_word,
    output logic [WORD_W-1:0] load_data
);
    // Purpose: build the store word and the load result for one access.
    // Latency: purely combinational.
    // Backpressure: none; no handshake.

    always_comb begin
        new_word  = store_data;
        load_data = old_word;
        if (is_byte) begin
            new_word  = old_word;
            load_data = '0;
            for (int i = 0; i < LANES_PER_WORD; i++) begin
                if (lane == 2'(i)) begin
                    new_word[i*LANE_W +: LANE_W]  = store_data[LANE_W-1:0];
                    load_data[LANE_W-1:0]         = old_word[i*LANE_W +: LANE_W];
                end
            end
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: word-organised RAM with programmable wait states.
// Ports: clock/reset (async, active-high); request_valid/ready/write/byte/
//        address/write_data in; response_valid/read_data/error out.
// Optional: define DMEM_FAULT_EN to flag misaligned word and out-of-range accesses.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        request_valid,
    output logic        request_ready,
    input  logic        request_write,
    input  logic        request_byte,
    input  logic [31:0] request_address,
    input  logic [31:0] request_write_data,
    output logic        response_valid,
    output logic [31:0] response_read_data,
    output logic        response_error
);
    // Purpose: accept load/store requests and answer from a word RAM.
    // Latency: response_valid one cycle pulse LATENCY+1 cycles after the accept cycle.
    // Backpressure: request_ready low during WAIT; held requests are not queued.

    localparam int         IDX_W    = index_width(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              byte_q, byte_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    logic              accept;
    logic              commit;
    logic              mem_we;
    logic              txn_write;
    logic              txn_byte;
    logic [31:0]       txn_addr;
    logic [31:0]       txn_wdata;
    logic [IDX_W-1:0]  txn_idx;
    logic              txn_fault;
    logic [WORD_W-1:0] old_word;
    logic [WORD_W-1:0] new_word;
    logic [WORD_W-1:0] load_data;

    assign accept = request_valid && request_ready;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESPOND: begin
                state_d = IDLE;
                if (accept) begin
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESPOND;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state flops only.
    always_comb begin
        request_ready  = (state_q != WAIT);
        response_valid = (state_q == RESPOND);
    end

    // Request capture on accept.
    always_comb begin
        wr_d    = wr_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            wr_d    = request_write;
            byte_d  = request_byte;
            addr_d  = request_address;
            wdata_d = request_write_data;
        end
    end

    // Every transition into RESPOND is exactly one commit. With zero wait
    // states that edge is also the accepting edge, so the live request is used.
    assign commit    = (state_d == RESPOND);
    assign txn_write = (LATENCY == 0) ? request_write      : wr_q;
    assign txn_byte  = (LATENCY == 0) ? request_byte       : byte_q;
    assign txn_addr  = (LATENCY == 0) ? request_address    : addr_q;
    assign txn_wdata = (LATENCY == 0) ? request_write_data : wdata_q;
    assign txn_idx   = txn_addr[IDX_W+1:2];

`ifdef DMEM_FAULT_EN
    localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * 4);
    assign txn_fault = (!txn_byte && (txn_addr[1:0] != 2'b00)) ||
                       (txn_addr >= BYTE_LIMIT);
`else
    // Upper address bits only matter for range faults; they wrap otherwise.
    logic unused_addr_bits;
    assign unused_addr_bits = ^txn_addr[31:IDX_W+2];
    assign txn_fault        = 1'b0;
`endif

    assign old_word = mem_q[txn_idx];

    byte_lane_merge u_merge (
        .old_word   (old_word),
        .store_data (txn_wdata),
        .lane       (txn_addr[1:0]),
        .is_byte    (txn_byte),
        .new_word   (new_word),
        .load_data  (load_data)
    );

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        if (commit) begin
            err_d   = txn_fault;
            mem_we  = txn_write && !txn_fault;
            rdata_d = (txn_write || txn_fault) ? 32'h0 : load_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q    <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset; a reset coinciding with the commit edge drops the store.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem_q[txn_idx] <= new_word;
        end
    end

    assign response_read_data = rdata_q;
    assign response_error     = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: one LATENCY=2 and one LATENCY=0 instance,
// directed scenarios plus randomized traffic against an array-based model.
module tb_data_memory_responder;

    logic clk;
    logic rst;

    logic        a_vld, a_wr, a_byte, a_rdy, a_rvld, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_vld, b_wr, b_byte, b_rdy, b_rvld, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [2][64];

`ifdef DMEM_FAULT_EN
    localparam logic FAULTS = 1'b1;
`else
    localparam logic FAULTS = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut_a (
        .clock(clk), .reset(rst),
        .request_valid(a_vld), .request_ready(a_rdy), .request_write(a_wr),
        .request_byte(a_byte), .request_address(a_addr), .request_write_data(a_wdata),
        .response_valid(a_rvld), .response_read_data(a_rdata), .response_error(a_err)
    );

    data_memory_responder #(.DEPTH_WORDS(64), .LATENCY(0)) u_dut_b (
        .clock(clk), .reset(rst),
        .request_valid(b_vld), .request_ready(b_rdy), .request_write(b_wr),
        .request_byte(b_byte), .request_address(b_addr), .request_write_data(b_wdata),
        .response_valid(b_rvld), .response_read_data(b_rdata), .response_error(b_err)
    );

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : 0;
    endfunction

    function automatic logic get_rdy(input int s);
        return (s == 0) ? a_rdy : b_rdy;
    endfunction
    function automatic logic get_rvld(input int s);
        return (s == 0) ? a_rvld : b_rvld;
    endfunction
    function automatic logic [31:0] get_rdata(input int s);
        return (s == 0) ? a_rdata : b_rdata;
    endfunction
    function automatic logic get_err(input int s);
        return (s == 0) ? a_err : b_err;
    endfunction

    task automatic drive(input int s, input logic v, input logic w, input logic b,
                         input logic [31:0] ad, input logic [31:0] d);
        if (s == 0) begin
            a_vld = v; a_wr = w; a_byte = b; a_addr = ad; a_wdata = d;
        end else begin
            b_vld = v; b_wr = w; b_byte = b; b_addr = ad; b_wdata = d;
        end
    endtask

    // Reference model: a 64-word little-endian array; returns expected data/error.
    task automatic model_access(input int s, input logic wr, input logic byt,
                                input logic [31:0] addr, input logic [31:0] data,
                                output logic [31:0] exp_data, output logic exp_err);
        int idx;
        int sh;
        logic [31:0] mask;
        idx      = int'((addr / 4) % 64);
        sh       = int'(addr % 4) * 8;
        exp_err  = FAULTS && ((!byt && (addr % 4) != 0) || addr >= 256);
        exp_data = 32'h0;
        if (exp_err) return;
        if (wr) begin
            if (byt) begin
                mask = 32'hFF << sh;
                mdl[s][idx] = (mdl[s][idx] & ~mask) | ((data & 32'hFF) << sh);
            end else begin
                mdl[s][idx] = data;
            end
        end else begin
            exp_data = byt ? ((mdl[s][idx] >> sh) & 32'hFF) : mdl[s][idx];
        end
    endtask

    // One request; lat counts cycles from the accept cycle to the response cycle.
    task automatic txn(input int s, input logic wr, input logic byt,
                       input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        rdata = 32'h0;
        err   = 1'b0;
        lat   = 0;
        @(negedge clk);
        drive(s, 1'b1, wr, byt, addr, data);
        guard = 0;
        while (!get_rdy(s) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!get_rdy(s)) begin
            total++; bad++;
            $display("FAIL accept_timeout inst=%0d got ready=0 want ready=1", s);
            drive(s, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            return;
        end
        @(negedge clk);
        drive(s, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        lat = 1;
        while (!get_rvld(s) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!get_rvld(s)) begin
            total++; bad++;
            $display("FAIL response_timeout inst=%0d got valid=0 want valid=1", s);
            return;
        end
        rdata = get_rdata(s);
        err   = get_err(s);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            total++; if (get_rdy(s) !== 1'b1) begin bad++; $display("FAIL reset_ready inst=%0d got %b want 1", s, get_rdy(s)); end
            total++; if (get_rvld(s) !== 1'b0) begin bad++; $display("FAIL reset_valid inst=%0d got %b want 0", s, get_rvld(s)); end
            total++; if (get_rdata(s) !== 32'h0) begin bad++; $display("FAIL reset_rdata inst=%0d got %h want 0", s, get_rdata(s)); end
            total++; if (get_err(s) !== 1'b0) begin bad++; $display("FAIL reset_error inst=%0d got %b want 0", s, get_err(s)); end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word();
        logic [31:0] rd, ed;
        logic er, ee;
        int lat;
        model_access(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, ed, ee);
        txn(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
        total++; if (lat !== lat_of(0) + 1) begin bad++; $display("FAIL word_store_latency got %0d want %0d", lat, lat_of(0) + 1); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL word_store_rdata got %h want 0", rd); end
        @(negedge clk);
        total++; if (a_rvld !== 1'b0) begin bad++; $display("FAIL response_pulse_width got %b want 0", a_rvld); end
        model_access(0, 1'b0, 1'b0, 32'h10, 32'h0, ed, ee);
        txn(0, 1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_load_data got %h want deadbeef", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL word_load_error got %b want 0", er); end
        total++; if (lat !== lat_of(0) + 1) begin bad++; $display("FAIL word_load_latency got %0d want %0d", lat, lat_of(0) + 1); end
    endtask

    task automatic test_byte();
        logic [31:0] rd, ed;
        logic er, ee;
        int lat;
        model_access(0, 1'b1, 1'b0, 32'h10, 32'h11223344, ed, ee);
        txn(0, 1'b1, 1'b0, 32'h10, 32'h11223344, rd, er, lat);
        // Upper data bits are junk: only [7:0] may land in the lane.
        model_access(0, 1'b1, 1'b1, 32'h13, 32'h5A5A5AAB, ed, ee);
        txn(0, 1'b1, 1'b1, 32'h13, 32'h5A5A5AAB, rd, er, lat);
        model_access(0, 1'b0, 1'b0, 32'h10, 32'h0, ed, ee);
        txn(0, 1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        total++; if (rd !== 32'hAB223344) begin bad++; $display("FAIL byte_merge_word got %h want ab223344", rd); end
        model_access(0, 1'b0, 1'b1, 32'h12, 32'h0, ed, ee);
        txn(0, 1'b0, 1'b1, 32'h12, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h00000022) begin bad++; $display("FAIL byte_load_lane2 got %h want 00000022", rd); end
        txn(0, 1'b0, 1'b1, 32'h13, 32'h0, rd, er, lat);
        total++; if (rd !== 32'h000000AB) begin bad++; $display("FAIL byte_load_lane3 got %h want 000000ab", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, ed, rd1, rd2;
        logic ee, rdy_at;
        int t1, t2, n;
        d = $urandom;
        model_access(0, 1'b1, 1'b0, 32'h20, d, ed, ee);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b0, 32'h20, d);
        total++; if (a_rdy !== 1'b1) begin bad++; $display("FAIL b2b_idle_ready got %b want 1", a_rdy); end
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        t1 = 0; t2 = 0; n = 0; rdy_at = 1'b0; rd1 = 32'h0; rd2 = 32'h0;
        for (int t = 1; t <= 20; t++) begin
            if (a_rvld === 1'b1) begin
                if (n == 0) begin
                    t1 = t; rdy_at = a_rdy; rd1 = a_rdata; n = 1;
                end else if (n == 1) begin
                    t2 = t; rd2 = a_rdata; n = 2;
                end
            end
            if (n == 1 && t == t1 + 1) drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (n == 2) break;
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        total++; if (t1 !== lat_of(0) + 1) begin bad++; $display("FAIL b2b_store_latency got %0d want %0d", t1, lat_of(0) + 1); end
        total++; if (rdy_at !== 1'b1) begin bad++; $display("FAIL b2b_respond_ready got %b want 1", rdy_at); end
        total++; if (t2 - t1 !== lat_of(0) + 1) begin bad++; $display("FAIL b2b_load_spacing got %0d want %0d", t2 - t1, lat_of(0) + 1); end
        total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL b2b_store_rdata got %h want 0", rd1); end
        total++; if (rd2 !== d) begin bad++; $display("FAIL b2b_load_data got %h want %h", rd2, d); end
    endtask

    task automatic test_latency0();
        logic [31:0] rd, d;
        logic er;
        int lat;
        logic [31:0] addrs [3];
        logic        bytes [3];
        logic [31:0] exp_d [3];
        logic        exp_e [3];
        d = $urandom;
        model_access(1, 1'b1, 1'b0, 32'h30, d, rd, er);
        txn(1, 1'b1, 1'b0, 32'h30, d, rd, er, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL lat0_store_latency got %0d want 1", lat); end
        addrs = '{32'h30, 32'h31, 32'h33};
        bytes = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) model_access(1, 1'b0, bytes[k], addrs[k], 32'h0, exp_d[k], exp_e[k]);
        @(negedge clk);
        for (int k = 0; k <= 3; k++) begin
            total++; if (b_rdy !== 1'b1) begin bad++; $display("FAIL lat0_ready k=%0d got %b want 1", k, b_rdy); end
            if (k > 0) begin
                total++; if (b_rvld !== 1'b1) begin bad++; $display("FAIL lat0_valid k=%0d got %b want 1", k, b_rvld); end
                total++; if (b_rdata !== exp_d[k-1]) begin bad++; $display("FAIL lat0_data k=%0d got %h want %h", k, b_rdata, exp_d[k-1]); end
            end
            if (k < 3) drive(1, 1'b1, 1'b0, bytes[k], addrs[k], 32'h0);
            else       drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
        end
        total++; if (b_rvld !== 1'b0) begin bad++; $display("FAIL lat0_idle_valid got %b want 0", b_rvld); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, ed, addr, val;
        logic er, ee, seen;
        int lat;
        for (int c = 1; c <= 2; c++) begin
            addr = (c == 1) ? 32'h04 : 32'h08;
            val  = (c == 1) ? 32'h55 : 32'h77;
            model_access(0, 1'b1, 1'b0, addr, 32'h0, ed, ee);
            txn(0, 1'b1, 1'b0, addr, 32'h0, rd, er, lat);
            @(negedge clk);
            drive(0, 1'b1, 1'b1, 1'b0, addr, val);
            @(negedge clk);
            drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            seen = a_rvld;
            if (c == 2) begin
                @(negedge clk);
                seen = seen | a_rvld;
            end
            rst = 1'b1;
            @(negedge clk);
            total++; if (a_rdy !== 1'b1) begin bad++; $display("FAIL reset_mid_ready c=%0d got %b want 1", c, a_rdy); end
            seen = seen | a_rvld;
            rst = 1'b0;
            repeat (4) begin
                @(negedge clk);
                seen = seen | a_rvld;
            end
            total++; if (seen !== 1'b0) begin bad++; $display("FAIL reset_mid_no_response c=%0d got %b want 0", c, seen); end
            model_access(0, 1'b0, 1'b0, addr, 32'h0, ed, ee);
            txn(0, 1'b0, 1'b0, addr, 32'h0, rd, er, lat);
            total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_mid_dropped c=%0d got %h want 0", c, rd); end
        end
    endtask

    task automatic test_fault();
        logic [31:0] rd, ed, w0;
        logic er, ee;
        int lat;
        w0 = $urandom;
        model_access(0, 1'b1, 1'b0, 32'h0, w0, ed, ee);
        txn(0, 1'b1, 1'b0, 32'h0, w0, rd, er, lat);
        model_access(0, 1'b1, 1'b0, 32'h102, 32'hCAFEF00D, ed, ee);
        txn(0, 1'b1, 1'b0, 32'h102, 32'hCAFEF00D, rd, er, lat);
        total++; if (er !== FAULTS) begin bad++; $display("FAIL fault_store_error got %b want %b", er, FAULTS); end
        total++; if (lat !== lat_of(0) + 1) begin bad++; $display("FAIL fault_store_latency got %0d want %0d", lat, lat_of(0) + 1); end
        model_access(0, 1'b0, 1'b0, 32'h0, 32'h0, ed, ee);
        txn(0, 1'b0, 1'b0, 32'h0, 32'h0, rd, er, lat);
        total++; if (rd !== (FAULTS ? w0 : 32'hCAFEF00D)) begin bad++; $display("FAIL fault_word0_contents got %h want %h", rd, FAULTS ? w0 : 32'hCAFEF00D); end
        model_access(0, 1'b0, 1'b0, 32'h100, 32'h0, ed, ee);
        txn(0, 1'b0, 1'b0, 32'h100, 32'h0, rd, er, lat);
        total++; if (er !== FAULTS) begin bad++; $display("FAIL fault_range_error got %b want %b", er, FAULTS); end
        total++; if (rd !== (FAULTS ? 32'h0 : 32'hCAFEF00D)) begin bad++; $display("FAIL fault_range_data got %h want %h", rd, FAULTS ? 32'h0 : 32'hCAFEF00D); end
        model_access(0, 1'b0, 1'b0, 32'h12, 32'h0, ed, ee);
        txn(0, 1'b0, 1'b0, 32'h12, 32'h0, rd, er, lat);
        total++; if (er !== ee || rd !== ed) begin bad++; $display("FAIL fault_misaligned_load got %h/%b want %h/%b", rd, er, ed, ee); end
    endtask

    task automatic test_random(input int s, input int n);
        logic [31:0] rd, ed, addr, data;
        logic er, ee, wr, byt;
        int lat;
        for (int i = 0; i < 64; i++) begin
            data = $urandom;
            model_access(s, 1'b1, 1'b0, 32'(i * 4), data, ed, ee);
            txn(s, 1'b1, 1'b0, 32'(i * 4), data, rd, er, lat);
        end
        for (int i = 0; i < n; i++) begin
            wr   = 1'($urandom_range(0, 1));
            byt  = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 255);
            data = $urandom;
            model_access(s, wr, byt, addr, data, ed, ee);
            txn(s, wr, byt, addr, data, rd, er, lat);
            total++; if (rd !== ed) begin bad++; $display("FAIL rand_data inst=%0d i=%0d wr=%b byte=%b addr=%h got %h want %h", s, i, wr, byt, addr, rd, ed); end
            total++; if (er !== ee) begin bad++; $display("FAIL rand_error inst=%0d i=%0d addr=%h got %b want %b", s, i, addr, er, ee); end
            total++; if (lat !== lat_of(s) + 1) begin bad++; $display("FAIL rand_latency inst=%0d i=%0d got %0d want %0d", s, i, lat, lat_of(s) + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_back_to_back();
        test_latency0();
        test_reset_mid();
        test_fault();
        test_random(0, 150);
        test_random(1, 100);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
